// File: rtl/lab5_divider.sv
// rtl/lab5_divider.sv - Sequential unsigned restoring divider, one quotient bit per clock
//
// Purpose: divides a WIDTH_A-bit dividend by a WIDTH_B-bit divisor, producing
// a WIDTH_A-bit quotient and WIDTH_B-bit remainder after exactly WIDTH_A
// iterations. Start/busy/done handshake; results hold until the next result.
//
// Ports:
//   clk     - clock, all state changes on the rising edge
//   reset   - synchronous, active-high reset
//   start   - request, accepted when not busy (IDLE or DONE)
//   in_a    - dividend, captured on the accepting edge
//   in_b    - divisor, captured on the accepting edge
//   busy    - high while iterating
//   done    - one-cycle pulse; out_q/out_r valid from this cycle on
//   out_q   - quotient (all ones for a zero divisor)
//   out_r   - remainder (in_a[WIDTH_B-1:0] for a zero divisor)
//   out_err - only with LAB5_DIV_ZERO_ERR_EN: 1 when the divisor was zero
//
// Optional feature macro: LAB5_DIV_ZERO_ERR_EN

module lab5_divider #(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH_A-1:0] in_a,
    input  logic [WIDTH_B-1:0] in_b,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_A-1:0] out_q,
    output logic [WIDTH_B-1:0] out_r
`ifdef LAB5_DIV_ZERO_ERR_EN
    ,
    output logic               out_err
`endif
);

    localparam int CW = $clog2(WIDTH_A) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH_A - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // a_reg starts as the dividend and shifts left each iteration; quotient
    // bits enter at the LSB, so it holds the full quotient after WIDTH_A steps.
    logic [WIDTH_A-1:0] a_reg;
    logic [WIDTH_B-1:0] b_reg;
    logic [WIDTH_B-1:0] p_reg;
    logic [CW-1:0]      count;

    logic               accept;
    logic               last_iter;
    logic [WIDTH_B:0]   p_shift;
    logic               q_bit;
    logic [WIDTH_B-1:0] p_next;
    logic [WIDTH_A-1:0] a_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept    = start && (state == IDLE || state == DONE);
    assign last_iter = (count == LAST_ITER);

    // One restoring step. The stored partial remainder is always below the
    // divisor, so only the shifted value needs the extra bit; the difference
    // fits WIDTH_B bits and modulo subtraction on the low bits is exact.
    // A zero divisor makes every step subtract nothing, which naturally
    // yields an all-ones quotient and the dividend's low bits as remainder.
    always_comb begin
        p_shift = {p_reg, a_reg[WIDTH_A-1]};
        q_bit   = (p_shift >= {1'b0, b_reg});
        p_next  = q_bit ? (p_shift[WIDTH_B-1:0] - b_reg) : p_shift[WIDTH_B-1:0];
        a_next  = {a_reg[WIDTH_A-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            p_reg   <= '0;
            count   <= '0;
            out_q   <= '0;
            out_r   <= '0;
`ifdef LAB5_DIV_ZERO_ERR_EN
            out_err <= 1'b0;
`endif
        end else if (accept) begin
            a_reg <= in_a;
            b_reg <= in_b;
            p_reg <= '0;
            count <= '0;
        end else if (state == RUN) begin
            a_reg <= a_next;
            p_reg <= p_next;
            count <= count + 1'b1;
            if (last_iter) begin
                out_q   <= a_next;
                out_r   <= p_next;
`ifdef LAB5_DIV_ZERO_ERR_EN
                out_err <= (b_reg == '0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_lab5_divider.sv
// tb/tb_lab5_divider.sv - Self-checking bench for lab5_divider with a behavioural model

module tb_lab5_divider;

    localparam int WA = 8;
    localparam int WB = 3;

    logic          clk;
    logic          reset;
    logic          start;
    logic [WA-1:0] in_a;
    logic [WB-1:0] in_b;
    logic          busy;
    logic          done;
    logic [WA-1:0] out_q;
    logic [WB-1:0] out_r;
`ifdef LAB5_DIV_ZERO_ERR_EN
    logic          out_err;
`endif

    lab5_divider #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_a    (in_a),
        .in_b    (in_b),
        .busy    (busy),
        .done    (done),
        .out_q   (out_q),
        .out_r   (out_r)
`ifdef LAB5_DIV_ZERO_ERR_EN
        ,
        .out_err (out_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: an operation accepted while idle finishes WIDTH_A
    // edges later with results from plain / and %.
    int m_left = 0;
    int m_a    = 0;
    int m_b    = 0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_q    = 0;
    int m_r    = 0;
    int m_err  = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_q    = 0;
            m_r    = 0;
            m_err  = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    if (m_b == 0) begin
                        m_q   = (1 << WA) - 1;
                        m_r   = m_a % (1 << WB);
                        m_err = 1;
                    end else begin
                        m_q   = m_a / m_b;
                        m_r   = m_a % m_b;
                        m_err = 0;
                    end
                end
            end else if (start) begin
                m_a    = int'(in_a);
                m_b    = int'(in_b);
                m_left = WA;
            end
        end
        m_busy = (m_left > 0);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", int'(busy), int'(m_busy));
            check("done", int'(done), int'(m_done));
            check("out_q", int'(out_q), m_q);
            check("out_r", int'(out_r), m_r);
`ifdef LAB5_DIV_ZERO_ERR_EN
            check("out_err", int'(out_err), m_err);
`endif
        end
    end

    // Waits (at negedges) for done, starting from lat0 edges after acceptance.
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done && lat < 4 * WA) begin
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            check("done_timeout", 0, 1);
        end
    endtask

    // Issues one operation from a negedge, scrambles operands during RUN,
    // and returns at the negedge where done is high.
    task automatic do_op(input int a, input int b, output int lat);
        start = 1'b1;
        in_a  = WA'(a);
        in_b  = WB'(b);
        @(negedge clk);
        start = 1'b0;
        in_a  = WA'($urandom);
        in_b  = WB'($urandom);
        wait_done(0, lat);
    endtask

    task automatic op_literal(input string name, input int a, input int b,
                              input int eq, input int er);
        int lat;
        do_op(a, b, lat);
        check({name, "_lat"}, lat, WA);
        check({name, "_q"}, int'(out_q), eq);
        check({name, "_r"}, int'(out_r), er);
        @(negedge clk);
        check({name, "_done_pulse"}, int'(done), 0);
    endtask

    initial begin
        int lat;
        int seen;
        int a;
        int b;

        reset = 1'b1;
        start = 1'b0;
        in_a  = '0;
        in_b  = '0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_q", int'(out_q), 0);
        check("rst_r", int'(out_r), 0);
        repeat (5) @(negedge clk);
        check("idle_q", int'(out_q), 0);
        check("idle_busy", int'(busy), 0);

        op_literal("div200_7", 200, 7, 28, 4);
        op_literal("div255_1", 255, 1, 255, 0);
        op_literal("div5_6", 5, 6, 0, 5);
        op_literal("div0_7", 0, 7, 0, 0);

        do_op(43, 0, lat);
        check("div43_0_lat", lat, WA);
        check("div43_0_q", int'(out_q), 255);
        check("div43_0_r", int'(out_r), 3);
`ifdef LAB5_DIV_ZERO_ERR_EN
        check("div43_0_err", int'(out_err), 1);
`endif
        @(negedge clk);
        do_op(42, 6, lat);
        check("div42_6_q", int'(out_q), 7);
        check("div42_6_r", int'(out_r), 0);
`ifdef LAB5_DIV_ZERO_ERR_EN
        check("div42_6_err", int'(out_err), 0);
`endif
        @(negedge clk);

        // start while busy is ignored
        start = 1'b1;
        in_a  = 8'd100;
        in_b  = 3'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        in_a  = 8'd9;
        in_b  = 3'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, lat);
        check("busy_start_lat", lat, WA);
        check("busy_start_q", int'(out_q), 33);
        check("busy_start_r", int'(out_r), 1);

        // start in the DONE cycle is accepted
        do_op(9, 2, lat);
        check("done_start_lat", lat, WA);
        check("done_start_q", int'(out_q), 4);
        check("done_start_r", int'(out_r), 1);
        @(negedge clk);

        // reset mid-RUN aborts without a done pulse
        start = 1'b1;
        in_a  = 8'd200;
        in_b  = 3'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_q", int'(out_q), 0);
        check("abort_r", int'(out_r), 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", seen, 0);
        op_literal("div50_4", 50, 4, 12, 2);

        // randomized operations, with stray starts during RUN and
        // back-to-back starts in the DONE cycle
        repeat (200) begin
            a = int'($urandom_range(0, (1 << WA) - 1));
            b = int'($urandom_range(0, (1 << WB) - 1));
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1;
                in_a  = WA'(a);
                in_b  = WB'(b);
                @(negedge clk);
                start = 1'b0;
                repeat ($urandom_range(0, WA - 3)) @(negedge clk);
                start = 1'b1;
                in_a  = WA'($urandom);
                in_b  = WB'($urandom);
                @(negedge clk);
                start = 1'b0;
                wait_done(1, lat);
            end else begin
                do_op(a, b, lat);
            end
            if (b != 0) begin
                check("roundtrip", int'(out_q) * b + int'(out_r), a);
            end else begin
                check("zero_div_q", int'(out_q), (1 << WA) - 1);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
